// File: rtl/sa_global_ctrl_if.sv
// Switch-allocator global stage bus: local-stage requests in, per-output grants,
// input pop enables and credit state out.
interface sa_global_ctrl_if #(
    parameter int INPUT_PORT_NUM  = 5,
    parameter int OUTPUT_PORT_NUM = 5,
    parameter int CREDIT_W        = 3
);
    logic [INPUT_PORT_NUM-1:0][OUTPUT_PORT_NUM-1:0]  sa_local_vld_to_sa_global_i;
    logic [INPUT_PORT_NUM-1:0]                       sa_local_tail_i;
    logic [OUTPUT_PORT_NUM-1:0]                      credit_return_i;
    logic [OUTPUT_PORT_NUM-1:0][INPUT_PORT_NUM-1:0]  sa_global_grt_oh_o;
    logic [OUTPUT_PORT_NUM-1:0]                      sa_global_grt_vld_o;
    logic [INPUT_PORT_NUM-1:0]                       inport_read_enable_o;
    logic [OUTPUT_PORT_NUM-1:0][CREDIT_W-1:0]        outport_credit_o;
    logic                                            credit_err_o;

    modport master (
        output sa_local_vld_to_sa_global_i, sa_local_tail_i, credit_return_i,
        input  sa_global_grt_oh_o, sa_global_grt_vld_o, inport_read_enable_o,
               outport_credit_o, credit_err_o
    );

    modport slave (
        input  sa_local_vld_to_sa_global_i, sa_local_tail_i, credit_return_i,
        output sa_global_grt_oh_o, sa_global_grt_vld_o, inport_read_enable_o,
               outport_credit_o, credit_err_o
    );
endinterface

// File: rtl/sa_global_ctrl.sv
// Global switch-allocation stage: per-output round-robin arbiter gated by downstream credits.
// Optional wormhole packet locking is enabled by defining SA_GLOBAL_PKT_LOCK_EN.
module sa_global_ctrl_outport #(
    parameter int IN    = 5,
    parameter int CW    = 3,
    parameter int CINIT = 4
)(
    input  logic          clk,
    input  logic          rstn,
    input  logic [IN-1:0] i_req,
    input  logic [IN-1:0] i_tail,
    input  logic          i_credit_ret,
    output logic [IN-1:0] o_grt_oh,
    output logic          o_grt_vld,
    output logic [CW-1:0] o_credit,
    output logic          o_ovf
);
    localparam int PW = (IN > 1) ? $clog2(IN) : 1;

    logic [CW-1:0] r_credit;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_nxt;
    logic [IN-1:0] w_cand;
    logic [IN-1:0] w_pick;
    logic          w_found;
    logic          w_grt;
    logic          w_ptr_hold;
    int            w_idx;

`ifdef SA_GLOBAL_PKT_LOCK_EN
    logic          r_lock_vld;
    logic [PW-1:0] r_lock_idx;

    // A locked output only considers the packet owner.
    always_comb begin
        w_cand = i_req;
        if (r_lock_vld) w_cand = i_req & (IN'(1) << r_lock_idx);
    end
    assign w_ptr_hold = r_lock_vld;
`else
    logic w_unused_tail;
    assign w_unused_tail = ^i_tail;
    assign w_cand        = i_req;
    assign w_ptr_hold    = 1'b0;
`endif

    always_comb begin
        w_pick  = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < IN; off++) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= IN) w_idx = w_idx - IN;
            if (!w_found && w_cand[w_idx]) begin
                w_found       = 1'b1;
                w_pick[w_idx] = 1'b1;
                w_win         = PW'(w_idx);
            end
        end
    end

    // Credit gate uses the registered count only; a same-cycle return is not bypassed.
    assign w_grt     = w_found && (r_credit != '0) && rstn;
    assign o_grt_vld = w_grt;
    assign o_grt_oh  = w_grt ? w_pick : '0;
    assign o_credit  = r_credit;
    assign o_ovf     = i_credit_ret && !w_grt && (r_credit == CW'(CINIT));
    assign w_ptr_nxt = (w_win == PW'(IN - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit   <= CW'(CINIT);
            r_ptr      <= '0;
`ifdef SA_GLOBAL_PKT_LOCK_EN
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else begin
            case ({w_grt, i_credit_ret})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   if (r_credit != CW'(CINIT)) r_credit <= r_credit + 1'b1;
                default: ;
            endcase
            if (w_grt && !w_ptr_hold) r_ptr <= w_ptr_nxt;
`ifdef SA_GLOBAL_PKT_LOCK_EN
            if (w_grt) begin
                r_lock_vld <= !i_tail[w_win];
                r_lock_idx <= w_win;
            end
`endif
        end
    end
endmodule

module sa_global_ctrl #(
    parameter int INPUT_PORT_NUM  = 5,
    parameter int OUTPUT_PORT_NUM = 5,
    parameter int CREDIT_W        = 3,
    parameter int CREDIT_INIT     = 4
)(
    input  logic            clk,
    input  logic            rstn,
    sa_global_ctrl_if.slave bus
);
    localparam int IN  = INPUT_PORT_NUM;
    localparam int OUT = OUTPUT_PORT_NUM;

    logic [IN-1:0][OUT-1:0] w_req_lo;
    logic [OUT-1:0][IN-1:0] w_req_col;
    logic [OUT-1:0][IN-1:0] w_grt_oh;
    logic [OUT-1:0]         w_grt_vld;
    logic [OUT-1:0]         w_ovf;
    logic [OUT-1:0][CREDIT_W-1:0] w_credit;
    logic [IN-1:0]          w_rd_en;
    logic                   r_credit_err;

    // Each input may ask for one output only: keep its lowest set request bit.
    for (genvar gi = 0; gi < IN; gi++) begin : g_mask
        assign w_req_lo[gi] = bus.sa_local_vld_to_sa_global_i[gi]
                            & (~bus.sa_local_vld_to_sa_global_i[gi] + OUT'(1));
    end

    always_comb begin
        w_req_col = '0;
        w_rd_en   = '0;
        for (int i = 0; i < IN; i++) begin
            for (int j = 0; j < OUT; j++) begin
                w_req_col[j][i] = w_req_lo[i][j];
                w_rd_en[i]      = w_rd_en[i] | w_grt_oh[j][i];
            end
        end
    end

    for (genvar gj = 0; gj < OUT; gj++) begin : g_out
        sa_global_ctrl_outport #(
            .IN    (IN),
            .CW    (CREDIT_W),
            .CINIT (CREDIT_INIT)
        ) u_outport (
            .clk          (clk),
            .rstn         (rstn),
            .i_req        (w_req_col[gj]),
            .i_tail       (bus.sa_local_tail_i),
            .i_credit_ret (bus.credit_return_i[gj]),
            .o_grt_oh     (w_grt_oh[gj]),
            .o_grt_vld    (w_grt_vld[gj]),
            .o_credit     (w_credit[gj]),
            .o_ovf        (w_ovf[gj])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_credit_err <= 1'b0;
        else if (|w_ovf) r_credit_err <= 1'b1;
    end

    assign bus.sa_global_grt_oh_o   = w_grt_oh;
    assign bus.sa_global_grt_vld_o  = w_grt_vld;
    assign bus.inport_read_enable_o = w_rd_en;
    assign bus.outport_credit_o     = w_credit;
    assign bus.credit_err_o         = r_credit_err;
endmodule

// File: tb/tb_sa_global_ctrl.sv
// Randomized and directed bench for sa_global_ctrl against an array-based allocation model.
module tb_sa_global_ctrl;
    localparam int IN    = 5;
    localparam int OUT   = 5;
    localparam int CW    = 3;
    localparam int CINIT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sa_global_ctrl_if #(.INPUT_PORT_NUM(IN), .OUTPUT_PORT_NUM(OUT), .CREDIT_W(CW)) bus ();

    sa_global_ctrl #(
        .INPUT_PORT_NUM(IN), .OUTPUT_PORT_NUM(OUT), .CREDIT_W(CW), .CREDIT_INIT(CINIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [IN-1:0][OUT-1:0] d_vld;
    logic [IN-1:0]          d_tail;
    logic [OUT-1:0]         d_ret;

    int m_credit [OUT];
    int m_ptr    [OUT];
    bit m_lock_v [OUT];
    int m_lock_k [OUT];
    bit m_err;

    logic [OUT-1:0][IN-1:0] exp_oh;
    logic [OUT-1:0]         exp_vld;
    logic [IN-1:0]          exp_rden;
    int                     exp_k [OUT];

    logic [OUT-1:0][IN-1:0] last_oh;
    logic [IN-1:0]          last_rden;
    int exp036 [4];

    function automatic int lowest_out(input int i);
        for (int j = 0; j < OUT; j++) if (d_vld[i][j]) return j;
        return -1;
    endfunction

    function automatic int oh2idx(input logic [IN-1:0] oh);
        for (int i = 0; i < IN; i++) if (oh[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < OUT; j++) begin
            m_credit[j] = CINIT; m_ptr[j] = 0; m_lock_v[j] = 0; m_lock_k[j] = 0;
        end
        m_err = 0;
    endfunction

    function automatic void model_comb();
        exp_oh = '0; exp_vld = '0; exp_rden = '0;
        for (int j = 0; j < OUT; j++) begin
            exp_k[j] = -1;
            if (rstn && m_credit[j] > 0) begin
                for (int off = 0; off < IN; off++) begin
                    int k;
                    k = (m_ptr[j] + off) % IN;
                    if (exp_k[j] < 0 && lowest_out(k) == j && (!m_lock_v[j] || m_lock_k[j] == k))
                        exp_k[j] = k;
                end
            end
            if (exp_k[j] >= 0) begin
                exp_vld[j] = 1'b1;
                exp_oh[j][exp_k[j]] = 1'b1;
                exp_rden[exp_k[j]] = 1'b1;
            end
        end
    endfunction

    function automatic void model_update();
        for (int j = 0; j < OUT; j++) begin
            bit g;
            g = exp_vld[j];
            if (g && !d_ret[j]) m_credit[j]--;
            else if (!g && d_ret[j]) begin
                if (m_credit[j] == CINIT) m_err = 1;
                else m_credit[j]++;
            end
            if (g) begin
                if (!m_lock_v[j]) m_ptr[j] = (exp_k[j] + 1) % IN;
`ifdef SA_GLOBAL_PKT_LOCK_EN
                m_lock_v[j] = !d_tail[exp_k[j]];
                m_lock_k[j] = exp_k[j];
`endif
            end
        end
    endfunction

    task automatic drive();
        bus.sa_local_vld_to_sa_global_i = d_vld;
        bus.sa_local_tail_i             = d_tail;
        bus.credit_return_i             = d_ret;
    endtask

    task automatic step();
        drive();
        #1;
        model_comb();
        last_oh   = bus.sa_global_grt_oh_o;
        last_rden = bus.inport_read_enable_o;
        chk("grt_vld", bus.sa_global_grt_vld_o, exp_vld);
        chk("grt_oh", bus.sa_global_grt_oh_o, exp_oh);
        chk("rd_en", bus.inport_read_enable_o, exp_rden);
        @(posedge clk);
        model_update();
        #1;
        for (int j = 0; j < OUT; j++)
            chk($sformatf("credit%0d", j), bus.outport_credit_o[j], m_credit[j]);
        chk("err", bus.credit_err_o, m_err);
    endtask

    task automatic clear_in();
        d_vld = '0; d_tail = '0; d_ret = '0;
    endtask

    // Reset asserted with live requests: grants must stay low, state must be at init.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < IN; i++) d_vld[i] = OUT'($urandom_range(1, (1 << OUT) - 1));
        d_ret = '1;
        drive();
        #1;
        model_reset();
        chk("rst_grt_vld", bus.sa_global_grt_vld_o, '0);
        chk("rst_rd_en", bus.inport_read_enable_o, '0);
        for (int j = 0; j < OUT; j++)
            chk($sformatf("rst_credit%0d", j), bus.outport_credit_o[j], CINIT);
        chk("rst_err", bus.credit_err_o, 0);
        @(negedge clk);
        clear_in();
        drive();
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        int n, w, flits;
`ifdef SA_GLOBAL_PKT_LOCK_EN
        exp036 = '{0, 0, 0, 4};
`else
        exp036 = '{0, 4, 0, 4};
`endif
        clear_in();
        drive();
        model_reset();
        do_reset();

        // Inputs 1 and 3 fight for output 2 with no returns: 1,3,1,3 then starve.
        n = 0;
        for (int c = 0; c < 6; c++) begin
            clear_in();
            d_vld[1] = 5'b00100; d_vld[3] = 5'b00100;
            step();
            w = oh2idx(last_oh[2]);
            if (w >= 0) begin
                chk($sformatf("r032_win%0d", n), w, (n % 2 == 0) ? 1 : 3);
                n++;
            end
        end
        chk("r032_cnt", n, 4);
        chk("r032_cred", bus.outport_credit_o[2], 0);

        // Drain output 0, then a return must not be bypassed into the same cycle.
        for (int c = 0; c < 4; c++) begin
            clear_in(); d_vld[0] = 5'b00001; step();
        end
        chk("r033_drained", bus.outport_credit_o[0], 0);
        clear_in(); d_vld[0] = 5'b00001; d_ret[0] = 1'b1; step();
        chk("r033_nogrt", last_oh[0], '0);
        clear_in(); d_vld[0] = 5'b00001; step();
        chk("r033_grt", last_rden, 5'b00001);
        chk("r033_cred", bus.outport_credit_o[0], 0);

        // Return into a full output 4 is dropped and raises the sticky error.
        clear_in(); d_ret[4] = 1'b1; step();
        chk("r034_cred", bus.outport_credit_o[4], 4);
        chk("r034_err", bus.credit_err_o, 1);
        for (int c = 0; c < 3; c++) begin clear_in(); step(); end
        chk("r034_sticky", bus.credit_err_o, 1);
        do_reset();

        // Multi-bit request: only the lowest output is taken.
        clear_in(); d_vld[2] = 5'b01010; step();
        chk("r035_vld", last_oh[1], 5'b00100);
        chk("r035_rden", last_rden, 5'b00100);
        chk("r035_out3", last_oh[3], '0);

        // Three-flit packet from input 0 against single flits from input 4 on output 1.
        do_reset();
        flits = 3; n = 0;
        for (int c = 0; c < 8 && n < 4; c++) begin
            clear_in();
            d_ret[1] = 1'b1;
            if (flits > 0) begin d_vld[0] = 5'b00010; d_tail[0] = (flits == 1); end
            d_vld[4] = 5'b00010; d_tail[4] = 1'b1;
            step();
            w = oh2idx(last_oh[1]);
            if (w >= 0) begin
                chk($sformatf("r036_win%0d", n), w, exp036[n]);
                n++;
            end
            if (last_rden[0]) flits--;
        end
        chk("r036_cnt", n, 4);

        // Reset mid-packet with credit 1 on output 1: all state returns to init.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_in(); d_vld[0] = 5'b00010; step();
        end
        chk("r037_cred_pre", bus.outport_credit_o[1], 1);
        do_reset();
        chk("r037_cred", bus.outport_credit_o[1], 4);
        clear_in(); d_vld[2] = 5'b00010; d_vld[3] = 5'b00010; step();
        chk("r037_win", oh2idx(last_oh[1]), 2);

        // Random traffic with one reset in the middle.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            for (int i = 0; i < IN; i++) begin
                d_vld[i]  = ($urandom_range(0, 9) < 6) ? OUT'($urandom_range(0, (1 << OUT) - 1)) : '0;
                d_tail[i] = 1'($urandom_range(0, 1));
            end
            for (int j = 0; j < OUT; j++) d_ret[j] = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/sa_global_ctrl.md
SA_GLOBAL_CTRL -- requirements
Module: sa_global_ctrl

Interface
REQ-001 SHALL have parameter INPUT_PORT_NUM, default 5: number of router input ports (local-stage winners).
REQ-002 SHALL have parameter OUTPUT_PORT_NUM, default 5: number of router output ports.
REQ-003 SHALL have parameter CREDIT_W, default 3: width of each per-output credit counter.
REQ-004 SHALL have parameter CREDIT_INIT, default 4, which must satisfy CREDIT_INIT < 2**CREDIT_W: downstream buffer depth per output.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port sa_local_vld_to_sa_global_i, input, [INPUT_PORT_NUM][OUTPUT_PORT_NUM]: the local winner of input i requests output j.
REQ-008 SHALL have port sa_local_tail_i, input, [INPUT_PORT_NUM]: the requesting flit of input i is a packet tail.
REQ-009 SHALL have port credit_return_i, input, [OUTPUT_PORT_NUM]: the downstream buffer of output j freed one slot.
REQ-010 SHALL have port sa_global_grt_oh_o, output, [OUTPUT_PORT_NUM][INPUT_PORT_NUM]: one-hot winner per output.
REQ-011 SHALL have port sa_global_grt_vld_o, output, [OUTPUT_PORT_NUM]: output j granted this cycle.
REQ-012 SHALL have port inport_read_enable_o, output, [INPUT_PORT_NUM]: input i won an output and pops its flit; this drives the local arbiter update.
REQ-013 SHALL have port outport_credit_o, output, [OUTPUT_PORT_NUM][CREDIT_W]: registered credit count.
REQ-014 SHALL have port credit_err_o, output, 1 bit: sticky flag set by credit overflow.

Function
REQ-015 SHALL treat input i as requesting only its lowest-indexed set output bit, masking any higher bits (one output per input).
REQ-016 SHALL, per output j, grant combinationally in the same cycle among requesting inputs, round-robin, with highest priority at index ptr[j].
REQ-017 SHALL grant output j only when outport_credit_o[j] > 0, using the registered value with no same-cycle bypass of credit_return_i.
REQ-018 SHALL keep sa_global_grt_oh_o[j] all-zero when sa_global_grt_vld_o[j] = 0.
REQ-019 SHALL set inport_read_enable_o[i] = OR over j of sa_global_grt_oh_o[j][i], so that it is at most one-hot per input.
REQ-020 SHALL, on a grant of output j to input k, update ptr[j] to (k+1) mod INPUT_PORT_NUM at the next edge; without a grant, ptr[j] holds.
REQ-021 SHALL compute credit next = cur - grt_vld[j] + credit_return_i[j]; a simultaneous grant and return SHALL leave the count unchanged.
REQ-022 SHALL, on a return while the count equals CREDIT_INIT with no grant, ignore the return, hold the count, and set credit_err_o (sticky until reset).
REQ-023 SHALL never let the credit count underflow; REQ-017 guarantees this.
REQ-024 SHALL make a grant visible to credit and pointer state one cycle after the request (registered update).

Reset
REQ-025 SHALL, while rstn = 0, force all credits to CREDIT_INIT, all ptr to 0, all locks clear and credit_err_o to 0.
REQ-026 SHALL, while rstn = 0, force grant outputs to 0 regardless of requests.
REQ-027 SHALL, on reset assertion mid-packet (lock held), drop the lock immediately.

Configuration
REQ-028 SHALL support macro SA_GLOBAL_PKT_LOCK_EN; when defined, a grant of output j to input k with sa_local_tail_i[k] = 0 locks output j to input k.
REQ-029 SHALL, while output j is locked to input k, grant output j only to input k (credit still required), with ptr[j] held.
REQ-030 SHALL clear the lock on a granted tail flit; a single-flit packet (tail = 1 on its first grant) SHALL never lock.
REQ-031 SHALL, without SA_GLOBAL_PKT_LOCK_EN, keep sa_local_tail_i present but ignored and arbitrate every flit independently.

Verification
REQ-032 SHALL cover: after reset, inputs 1 and 3 request output 2 every cycle with the return tied to 0 -> grants alternate 1, 3, 1, 3, stop after 4 grants, outport_credit_o[2] = 0.
REQ-033 SHALL cover: credit[0] = 0, then credit_return_i[0] pulses with input 0 requesting output 0 -> no grant that cycle, grant next cycle, credit back to 0.
REQ-034 SHALL cover: credit[4] = 4 with credit_return_i[4] = 1 and no grant -> credit stays 4, credit_err_o = 1 and remains 1 until rstn is low.
REQ-035 SHALL cover: input 2 requesting outputs 1 and 3 (bits 0b01010) with no other requests -> only output 1 is granted and inport_read_enable_o = 0b00100.
REQ-036 SHALL cover, with SA_GLOBAL_PKT_LOCK_EN: input 0 sends a 3-flit packet to output 1 while input 4 also requests output 1 -> input 0 is granted 3 consecutive cycles, then input 4; without the macro the grants interleave 0, 4, 0, 4.
REQ-037 SHALL cover: rstn asserted while output 1 is locked and credit = 1 -> on release, credit = 4, no lock, ptr = 0.
